// File: rtl/bldc_pkg.sv
// Shared types, hall constants and commutation tables for the BLDC commutator.
package bldc_pkg;

    typedef enum logic [1:0] {RUN, DEAD, FAULT} bldc_state_e;

    localparam logic [2:0] HALL_INVALID_LO = 3'b000;
    localparam logic [2:0] HALL_INVALID_HI = 3'b111;

    function automatic logic [5:0] comm_fwd(input logic [2:0] hall);
        case (hall)
            3'b101:  return 6'b100100;
            3'b100:  return 6'b100001;
            3'b110:  return 6'b001001;
            3'b010:  return 6'b011000;
            3'b011:  return 6'b010010;
            3'b001:  return 6'b000110;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] comm_rev(input logic [2:0] hall);
        case (hall)
            3'b101:  return 6'b011000;
            3'b100:  return 6'b010010;
            3'b110:  return 6'b000110;
            3'b010:  return 6'b100100;
            3'b011:  return 6'b100001;
            3'b001:  return 6'b001001;
            default: return 6'b000000;
        endcase
    endfunction

    // Successor of a valid hall code when rotating forward.
    function automatic logic [2:0] hall_fwd_next(input logic [2:0] hall);
        case (hall)
            3'b101:  return 3'b100;
            3'b100:  return 3'b110;
            3'b110:  return 3'b010;
            3'b010:  return 3'b011;
            3'b011:  return 3'b001;
            3'b001:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic hall_valid(input logic [2:0] hall);
        return (hall != HALL_INVALID_LO) && (hall != HALL_INVALID_HI);
    endfunction

    function automatic logic signed [1:0] hall_step(input logic [2:0] prev, input logic [2:0] next);
        if (!hall_valid(prev) || !hall_valid(next)) begin
            return 2'sb00;
        end else if (next == hall_fwd_next(prev)) begin
            return 2'sb01;
        end else if (prev == hall_fwd_next(next)) begin
            return 2'sb11;
        end
        return 2'sb00;
    endfunction

endpackage

// File: rtl/bldc_channel.sv
// One drive channel: hall sync, duty latch, dead-time FSM and optional step counter.
// Define BLDC_COMM_CNT_EN to enable the signed commutation step counter.
module bldc_channel
    import bldc_pkg::*;
#(
    parameter int unsigned PWM_BITS = 10,
    parameter int unsigned DEADTIME = 8
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic [PWM_BITS-1:0] iPWM,
    input  logic                iWRAP,
    input  logic [PWM_BITS:0]   iDUTY,
    input  logic [2:0]          iHALL,
    input  logic                iFAULT_CLR,
    output logic [5:0]          oPHASES,
    output logic                oFAULT,
    output logic [15:0]         oCOMM_CNT
);

    localparam logic [7:0] DeadLoad = 8'(DEADTIME - 1);

    logic [2:0]          rHallMeta;
    logic [2:0]          rHallSync;
    logic [1:0]          rPrimed;
    logic [PWM_BITS-1:0] rMag;
    logic                rSign;
    bldc_state_e         rState;
    logic [7:0]          rDead;
    logic [5:0]          rLast;

    logic [PWM_BITS:0]   dutyAbs;
    logic [PWM_BITS-1:0] dutyMag;
    logic                hallOk;
    logic                hallBad;
    logic [5:0]          target;

    always_comb begin
        dutyAbs = iDUTY[PWM_BITS] ? (~iDUTY + (PWM_BITS+1)'(1)) : iDUTY;
        dutyMag = dutyAbs[PWM_BITS] ? '1 : dutyAbs[PWM_BITS-1:0];
        hallOk  = hall_valid(rHallSync);
        // The cleared synchroniser holds 000 until real pin data arrives; do not fault on it.
        hallBad = rPrimed[1] && !hallOk;
        target  = '0;
        if (iPWM < rMag) begin
            target = rSign ? comm_rev(rHallSync) : comm_fwd(rHallSync);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            rHallMeta <= '0;
            rHallSync <= '0;
            rPrimed   <= '0;
            rMag      <= '0;
            rSign     <= 1'b0;
            rState    <= RUN;
            rDead     <= '0;
            rLast     <= '0;
            oPHASES   <= '0;
            oFAULT    <= 1'b0;
        end else begin
            rHallMeta <= iHALL;
            rHallSync <= rHallMeta;
            rPrimed   <= {rPrimed[0], 1'b1};
            if (iWRAP) begin
                rMag  <= dutyMag;
                rSign <= iDUTY[PWM_BITS];
            end
            if (hallBad) begin
                rState  <= FAULT;
                oPHASES <= '0;
                oFAULT  <= 1'b1;
            end else begin
                unique case (rState)
                    RUN: begin
                        if ((target != '0) && (target != rLast)) begin
                            rState  <= DEAD;
                            rDead   <= DeadLoad;
                            oPHASES <= '0;
                        end else begin
                            oPHASES <= target;
                        end
                    end
                    DEAD: begin
                        if (rDead == '0) begin
                            rState  <= RUN;
                            oPHASES <= target;
                            if (target != '0) begin
                                rLast <= target;
                            end
                        end else begin
                            rDead <= rDead - 8'd1;
                        end
                    end
                    FAULT: begin
                        if (iFAULT_CLR && hallOk) begin
                            rState <= DEAD;
                            rDead  <= DeadLoad;
                            oFAULT <= 1'b0;
                        end
                    end
                    default: rState <= RUN;
                endcase
            end
        end
    end

`ifdef BLDC_COMM_CNT_EN
    logic [2:0]         rHallPrev;
    logic signed [15:0] rCommCnt;
    logic signed [1:0]  step;

    assign step = hall_step(rHallPrev, rHallSync);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            rHallPrev <= '0;
            rCommCnt  <= '0;
        end else begin
            rHallPrev <= rHallSync;
            rCommCnt  <= rCommCnt + {{14{step[1]}}, step};
        end
    end

    assign oCOMM_CNT = rCommCnt;
`else
    assign oCOMM_CNT = '0;
`endif

endmodule

// File: rtl/bldc_commutator.sv
// Shared PWM timebase feeding CHANNELS six-step commutation channels.
// Define BLDC_COMM_CNT_EN to enable per-channel commutation step counters.
module bldc_commutator #(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned PWM_BITS = 10,
    parameter int unsigned DEADTIME = 8
) (
    input  logic                               iCLK,
    input  logic                               iRESET,
    input  logic [CHANNELS*(PWM_BITS+1)-1:0]   iDUTY,
    input  logic [CHANNELS*3-1:0]              iHALL,
    input  logic [CHANNELS-1:0]                iFAULT_CLR,
    output logic [CHANNELS*6-1:0]              oPHASES,
    output logic [CHANNELS-1:0]                oFAULT,
    output logic                               oPWM_WRAP,
    output logic [CHANNELS*16-1:0]             oCOMM_CNT
);

    localparam logic [PWM_BITS-1:0] PwmPenult = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] rPWM;

    // Wrap is registered so it is high exactly while rPWM sits at its maximum.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            rPWM      <= '0;
            oPWM_WRAP <= 1'b0;
        end else begin
            rPWM      <= rPWM + PWM_BITS'(1);
            oPWM_WRAP <= (rPWM == PwmPenult);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gChannel
        bldc_channel #(
            .PWM_BITS (PWM_BITS),
            .DEADTIME (DEADTIME)
        ) uChannel (
            .iCLK       (iCLK),
            .iRESET     (iRESET),
            .iPWM       (rPWM),
            .iWRAP      (oPWM_WRAP),
            .iDUTY      (iDUTY[c*(PWM_BITS+1) +: (PWM_BITS+1)]),
            .iHALL      (iHALL[c*3 +: 3]),
            .iFAULT_CLR (iFAULT_CLR[c]),
            .oPHASES    (oPHASES[c*6 +: 6]),
            .oFAULT     (oFAULT[c]),
            .oCOMM_CNT  (oCOMM_CNT[c*16 +: 16])
        );
    end

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Multi-channel, parametrised six-step BLDC commutation and PWM engine for the MKR Vidor motor-control fabric. It replaces ad-hoc per-motor commutation with one shared PWM timebase and CHANNELS independent drive channels. Each channel adds hall synchronisation, period-aligned duty updates, dead-time insertion and sticky hall-fault detection. It sits between the PID/SPI register logic (signed duty in) and the gate-driver pins (6 phase lines per channel out).

## Interface
- CHANNELS, 1: number of motor channels (1..8).
- PWM_BITS, 10: PWM counter width; period = 2^PWM_BITS clocks.
- DEADTIME, 8: all-off clocks inserted before a new non-zero phase pattern (1..255).
- iCLK  in  1  system clock (wCLK24 domain).
- iRESET  in  1  synchronous, active-high reset.
- iDUTY  in  CHANNELS*(PWM_BITS+1)  signed duty per channel, two's complement; sign selects direction.
- iHALL  in  CHANNELS*3  raw asynchronous hall inputs, {H_A,H_B,H_C} per channel, H_A MSB.
- iFAULT_CLR  in  CHANNELS  per-channel fault clear, level-sampled.
- oPHASES  out  CHANNELS*6  gate pattern per channel, bits [5:0].
- oFAULT  out  CHANNELS  sticky invalid-hall fault.
- oPWM_WRAP  out  1  one-clock pulse when the PWM counter is at its maximum value.
- oCOMM_CNT  out  CHANNELS*16  signed commutation step counter (see Configuration).

## Operation
- Shared counter rPWM counts 0..2^PWM_BITS-1 and wraps. The counter value is max during the oPWM_WRAP cycle.
- Duty latch: at wrap each channel latches |iDUTY|, saturated to 2^PWM_BITS-1, and its sign. The most negative value clamps to magnitude 2^PWM_BITS-1.
- PWM on when rPWM < magnitude. Magnitude 0 means always off.
- Hall: 2-FF synchroniser per bit. The synced code is used for everything.
- Forward table (sign 0, magnitude>0): 101->100100, 100->100001, 110->001001, 010->011000, 011->010010, 001->000110.
- Reverse table (sign 1): 101->011000, 100->010010, 110->000110, 010->100100, 011->100001, 001->001001.
- Target = table(hall, sign) when PWM on, else 000000.
- Per-channel FSM:
  - RUN: drive target. If target is non-zero and differs from rLAST, the last non-zero pattern driven, go to DEAD with the dead counter = DEADTIME. Transitions to 000000 are immediate and stay in RUN.
  - DEAD: output 000000 and decrement. At 0, return to RUN and drive the current target, re-evaluated on that cycle.
  - FAULT: output 000000, oFAULT=1.
- Any state goes to FAULT when the synced hall is 000 or 111. FAULT has priority over DEAD and RUN.
- FAULT -> DEAD (full DEADTIME) when iFAULT_CLR=1 and the synced hall is valid on the same cycle. iFAULT_CLR while the hall is invalid has no effect.
- Reset: rPWM=0, all duty latches 0, rLAST=000000, FSM=RUN, oPHASES=0, oFAULT=0, oPWM_WRAP=0, oCOMM_CNT=0, synchronisers cleared.
- After reset, the first non-zero target always incurs DEADTIME, because rLAST=000000.
- Reset asserted mid-DEAD or mid-FAULT returns to the reset state on the next edge.

## Timing
- Hall edge to oPHASES change: 3 clocks (2 sync + 1 output register) when no dead time is needed; 3+DEADTIME clocks otherwise.
- Duty change: sampled only on the oPWM_WRAP cycle, effective from rPWM=0 on the next cycle. Mid-period iDUTY changes are ignored until the next wrap.
- Fault entry: oPHASES=0 and oFAULT=1 three clocks after the invalid code appears on the pins.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- BLDC_COMM_CNT_EN defined: each channel keeps a signed 16-bit counter.
  - +1 on a valid synced-hall change that matches the forward sequence order.
  - −1 on a valid change matching the reverse order.
  - Out-of-sequence jumps and changes into or out of invalid codes are ignored.
  - Wraps at 16 bits. Cleared by reset only.
- Not defined: oCOMM_CNT is tied to 0. The port remains so the instantiations do not change.

## Structure
- Package bldc_pkg holds:
  - the state enum {RUN, DEAD, FAULT}
  - the constants HALL_INVALID_LO=3'b000 and HALL_INVALID_HI=3'b111
  - the functions comm_fwd and comm_rev (hall code -> 6-bit pattern)
  - the function hall_step (prev, next -> −1/0/+1), used under BLDC_COMM_CNT_EN
- Sub-module bldc_channel (one per channel, generate loop) contains the synchroniser, duty latch, FSM, dead counter and step counter.
- The top level holds rPWM and oPWM_WRAP.

## Test plan
- PWM_BITS=10, iDUTY=+512, hall 101: after the first wrap plus DEADTIME=8, oPHASES=100100 for rPWM 0..511 and 000000 for 512..1023; no dead time at PWM re-entry.
- Hall sequence 101->100, duty +1023: oPHASES goes to 000000 for 8 clocks starting 3 clocks after the edge, then 100001.
- iDUTY=−1024: magnitude clamps to 1023; hall 010 drives 100100 (reverse table) for all but one count per period.
- Hall 111 mid-run: oPHASES=0 and oFAULT=1 after 3 clocks. iFAULT_CLR with hall still 111 has no effect. Hall set to 110, then iFAULT_CLR: 8 dead clocks, then drive resumes and oFAULT=0.
- iDUTY changed from +100 to +900 at rPWM=300: the period keeps 100; the next period uses 900.
- BLDC_COMM_CNT_EN: six forward steps give oCOMM_CNT=+6; then three reverse steps give +3; a jump 101->010 leaves the count unchanged.
